lifo_stack: RTL and testbench
=============================

# lifo_stack

Responder side of the calculator's stack command interface: a LIFO of WIDTH-bit words driven by single-cycle push/pop/replace/reset pulses. The top-of-stack word is held in a register, and the entries below it sit in a synchronous-read block RAM. The block reports the top word, the occupancy and a sticky error flag, and it raises out_vld when it can accept the next command. It sits directly under the calculator controller, which only issues a command while out_vld is high.

## Interface
- WIDTH, default 32: data word width.
- ADDR_BITS, default 9: capacity CAP = 2**ADDR_BITS entries (512 by default).
- clk  input  1: system clock; all logic is on the rising edge.
- reset  input  1: synchronous, active-high; also usable as a mid-operation clear command.
- push  input  1: one-cycle pulse; push in_num.
- pop  input  1: one-cycle pulse; discard the top entry.
- replace  input  1: one-cycle pulse; overwrite the top entry with in_num.
- in_num  input  WIDTH: data for push and replace; sampled on the same edge as the command.
- top  output  WIDTH: current top entry; 0 when the stack is empty.
- size  output  ADDR_BITS+1: number of entries, 0..CAP.
- error  output  1: sticky error flag.
- out_vld  output  1: high means idle and able to accept a command.

## Operation
- State machine states:
  - READY: out_vld=1.
  - WR: 1 cycle; used for push and replace.
  - RD_ADDR, then RD_DATA: 1 cycle each; used for pop.
- Command sampling: a command is only sampled in READY. The sampling edge moves the FSM out of READY, so out_vld is low in the very next cycle.
- Push, size<CAP:
  - If size>0, write top into ram[size-1].
  - top<=in_num; size<=size+1.
  - Go to WR, then READY.
- Push, size==CAP: error<=1; no change to storage, top or size; stay in READY.
- Pop, size>0:
  - size<=size-1.
  - If size>=2, read ram[size-2] and load it into top in RD_DATA. If size==1, top<=0.
  - Path is always RD_ADDR, then RD_DATA, then READY.
- Pop, size==0: error<=1; no change.
- Replace, size>0: top<=in_num; go to WR. Replace never touches the RAM.
- Replace, size==0: error<=1; no change. Replace never creates an entry.
- More than one of push/pop/replace high in the same READY cycle: error<=1; no operation.
- Any command pulse while out_vld=0: ignored, error<=1, the in-flight operation completes normally.
- error clears only on reset.
- Arithmetic:
  - size is unsigned with no wrap; the full/empty checks prevent overflow and underflow.
  - RAM address is size-1 for a push write and size-2 for a pop read. Both are ADDR_BITS wide and are used only when in range.
- Memory contents are not cleared by reset; storage is logically empty because size=0.

## Timing
- Reset values (the edge after reset is sampled high):
  - size=0, top=0, error=0, out_vld=1, FSM=READY.
- Reset mid-operation: any state goes to READY with the values above. A pending RAM read result is discarded.
- reset has priority over every command in the same cycle.
- Command sampled at edge E0:
  - size holds its new value after E0.
  - push/replace: top holds its new value after E0; out_vld is low for 1 cycle and high again after E1.
  - pop: top is not guaranteed between E0 and E2 and holds its final value after E2; out_vld is low for 2 cycles and high again after E2.
- Back-to-back: the earliest next command is the cycle in which out_vld is observed high. A push followed by a pop of the same word returns the pushed value.
- out_vld is registered (a decode of FSM state); it has no combinational path from the inputs.
- error is registered: it is set on the edge that samples the offending command.

## Test plan
- Reset, then push 0x11, push 0x22, push 0x33 (each after out_vld) -> size 3, top 0x33; then pop, pop -> top 0x22, then 0x11; each pop holds out_vld low for exactly 2 cycles; error=0.
- replace in_num=0xDEADBEEF on size=1 -> top 0xDEADBEEF, size 1, out_vld low for 1 cycle; then pop -> size 0, top 0.
- From empty: pop, then replace -> error=1 after the first edge, size 0, top 0 throughout; error stays 1 until reset, then reads 0.
- Push values 1..512 -> size 512, error 0; a 513th push -> error=1, size 512, top 512; then 512 pops return 511..1, then 0 (empty), in order.
- push and pop high in the same cycle at size 2 -> error=1, size 2, top unchanged; a push issued while out_vld=0 during a pop -> ignored, error=1, pop completes with the correct top.
- Assert reset during RD_DATA of a pop at size 5 -> next cycle size 0, top 0, error 0, out_vld 1; a subsequent push 0x7 -> top 0x7, size 1.

Source files
------------

// File: rtl/lifo_stack_if.sv
// Command/status bundle between the calculator controller (master) and the
// stack responder (slave).
interface lifo_stack_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 9
);
  logic                 push;
  logic                 pop;
  logic                 replace;
  logic [WIDTH-1:0]     in_num;
  logic [WIDTH-1:0]     top;
  logic [ADDR_BITS:0]   size;
  logic                 error;
  logic                 out_vld;

  modport master (
    output push, pop, replace, in_num,
    input  top, size, error, out_vld
  );

  modport slave (
    input  push, pop, replace, in_num,
    output top, size, error, out_vld
  );
endinterface

// File: rtl/lifo_stack.sv
// LIFO stack: top word in a register, deeper entries in a synchronous-read RAM.
// Commands are accepted only while out_vld is high; anything else sets the sticky error.
module lifo_stack #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 9
) (
  input  logic         clk,
  input  logic         reset,
  lifo_stack_if.slave  bus
);
  localparam int                 CAP      = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] CAP_SIZE = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] ONE_SIZE = {{ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    READY,
    WR,
    RD_ADDR,
    RD_DATA
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     top_q, top_d;
  logic [ADDR_BITS:0]   size_q, size_d;
  logic                 error_q, error_d;
  logic [WIDTH-1:0]     rdData_q;
  logic [WIDTH-1:0]     mem [CAP];
  logic [ADDR_BITS-1:0] memAddr;
  logic                 memWe;
  logic                 cmdAny;
  logic                 cmdMulti;
  logic                 isEmpty;
  logic                 isFull;

  assign cmdAny   = bus.push | bus.pop | bus.replace;
  assign cmdMulti = (bus.push & bus.pop) | (bus.push & bus.replace) | (bus.pop & bus.replace);
  assign isEmpty  = (size_q == '0);
  assign isFull   = (size_q == CAP_SIZE);
  // size-1 is the push slot in READY and, after the pop decrement, the pop read slot in RD_ADDR
  assign memAddr  = size_q[ADDR_BITS-1:0] - ADDR_BITS'(1);

  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    size_d  = size_q;
    error_d = error_q;
    memWe   = 1'b0;
    unique case (state_q)
      READY: begin
        if (cmdMulti) begin
          error_d = 1'b1;
        end else if (bus.push) begin
          if (isFull) begin
            error_d = 1'b1;
          end else begin
            memWe   = !isEmpty;
            top_d   = bus.in_num;
            size_d  = size_q + ONE_SIZE;
            state_d = WR;
          end
        end else if (bus.pop) begin
          if (isEmpty) begin
            error_d = 1'b1;
          end else begin
            size_d  = size_q - ONE_SIZE;
            state_d = RD_ADDR;
          end
        end else if (bus.replace) begin
          if (isEmpty) begin
            error_d = 1'b1;
          end else begin
            top_d   = bus.in_num;
            state_d = WR;
          end
        end
      end
      WR: begin
        if (cmdAny) error_d = 1'b1;
        state_d = READY;
      end
      RD_ADDR: begin
        if (cmdAny) error_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (cmdAny) error_d = 1'b1;
        top_d   = isEmpty ? '0 : rdData_q;
        state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= READY;
      top_q   <= '0;
      size_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      size_q  <= size_d;
      error_q <= error_d;
    end
  end

  // Storage is left uncleared on reset so it maps onto a plain block RAM
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= top_q;
    rdData_q <= mem[memAddr];
  end

  assign bus.top     = top_q;
  assign bus.size    = size_q;
  assign bus.error   = error_q;
  assign bus.out_vld = (state_q == READY);
endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios plus random commands
// compared against a queue-based model of the stack.
module tb_lifo_stack;
  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 9;
  localparam int CAP       = 2 ** ADDR_BITS;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [WIDTH-1:0] model[$];
  logic             modelErr;
  int               expLow;

  lifo_stack_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

  lifo_stack #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] expTop();
    return (model.size() > 0) ? model[model.size()-1] : '0;
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".top"}, 64'(bus.top), 64'(expTop()));
    checkValue({tag, ".size"}, 64'(bus.size), 64'(model.size()));
    checkValue({tag, ".error"}, 64'(bus.error), 64'(modelErr));
    checkValue({tag, ".out_vld"}, 64'(bus.out_vld), 64'd1);
  endtask

  // Called just after a negedge; drives one command pulse across the next rising edge
  task automatic issueCmd(input logic p, input logic o, input logic r, input logic [WIDTH-1:0] d);
    int n;
    n = int'(p) + int'(o) + int'(r);
    expLow = 0;
    if (n > 0) begin
      if (bus.out_vld !== 1'b1 || n > 1) modelErr = 1'b1;
      else if (p) begin
        if (model.size() == CAP) modelErr = 1'b1;
        else begin model.push_back(d); expLow = 1; end
      end else if (o) begin
        if (model.size() == 0) modelErr = 1'b1;
        else begin void'(model.pop_back()); expLow = 2; end
      end else begin
        if (model.size() == 0) modelErr = 1'b1;
        else begin model[model.size()-1] = d; expLow = 1; end
      end
    end
    bus.push = p; bus.pop = o; bus.replace = r; bus.in_num = d;
    @(negedge clk);
    bus.push = 1'b0; bus.pop = 1'b0; bus.replace = 1'b0;
  endtask

  task automatic waitReady(input string tag, output int low);
    low = 0;
    while (bus.out_vld !== 1'b1 && low < 8) begin
      low++;
      @(negedge clk);
    end
    checkValue({tag, ".ready"}, 64'(bus.out_vld), 64'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic p, input logic o, input logic r,
                               input logic [WIDTH-1:0] d);
    int low;
    int want;
    issueCmd(p, o, r, d);
    want = expLow;
    waitReady(tag, low);
    checkValue({tag, ".busy"}, 64'(low), 64'(want));
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model.delete();
    modelErr = 1'b0;
  endtask

  initial begin
    int low;
    int sel;
    reset = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.replace = 1'b0; bus.in_num = '0;
    model.delete();
    modelErr = 1'b0;
    expLow = 0;

    doReset();
    checkOutput("reset");

    applyStimulus("push11", 1, 0, 0, 32'h11);
    applyStimulus("push22", 1, 0, 0, 32'h22);
    applyStimulus("push33", 1, 0, 0, 32'h33);
    checkOutput("three");
    applyStimulus("pop1", 0, 1, 0, '0);
    checkOutput("pop1");
    applyStimulus("pop2", 0, 1, 0, '0);
    checkOutput("pop2");

    applyStimulus("repl", 0, 0, 1, 32'hDEADBEEF);
    checkOutput("repl");
    applyStimulus("popLast", 0, 1, 0, '0);
    checkOutput("popLast");

    applyStimulus("popEmpty", 0, 1, 0, '0);
    checkOutput("popEmpty");
    applyStimulus("replEmpty", 0, 0, 1, 32'h55);
    checkOutput("replEmpty");
    doReset();
    checkOutput("errClear");

    for (int i = 1; i <= CAP; i++) applyStimulus("fill", 1, 0, 0, WIDTH'(i));
    checkOutput("full");
    applyStimulus("overflow", 1, 0, 0, WIDTH'(CAP + 1));
    checkOutput("overflow");
    for (int i = 0; i < CAP; i++) begin
      applyStimulus("drain", 0, 1, 0, '0);
      checkOutput("drain");
    end

    doReset();
    applyStimulus("pA", 1, 0, 0, 32'hA1);
    applyStimulus("pB", 1, 0, 0, 32'hB2);
    applyStimulus("multi", 1, 1, 0, 32'hC3);
    checkOutput("multi");
    issueCmd(0, 1, 0, '0);
    issueCmd(1, 0, 0, 32'hEE);
    waitReady("busyPush", low);
    checkOutput("busyPush");

    doReset();
    for (int i = 0; i < 5; i++) applyStimulus("p5", 1, 0, 0, WIDTH'(32'h100 + i));
    checkOutput("five");
    issueCmd(0, 1, 0, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model.delete();
    modelErr = 1'b0;
    checkOutput("midReset");
    applyStimulus("push7", 1, 0, 0, 32'h7);
    checkOutput("push7");

    doReset();
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      applyStimulus("rndPush", 1, 0, 0, WIDTH'($urandom));
      else if (sel <= 6) applyStimulus("rndPop", 0, 1, 0, '0);
      else if (sel <= 8) applyStimulus("rndRepl", 0, 0, 1, WIDTH'($urandom));
      else               applyStimulus("rndMulti", 1, 0, 1, WIDTH'($urandom));
      checkOutput("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
